// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// both on magnitudes with sign fix-up in a final cycle; also services MTHI/MTLO.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     rs_q, rs_d;
    logic             is_div_q, is_div_d;
    logic             neg_rs_q, neg_rs_d;
    logic             neg_rt_q, neg_rt_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             done_q, done_d;

    logic             signed_in;
    logic [W:0]       mul_sum;
    logic [W:0]       div_top;
    logic [W:0]       div_diff;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo;
    logic [W-1:0]     rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        rs_d     = rs_q;
        is_div_d = is_div_q;
        neg_rs_d = neg_rs_q;
        neg_rt_d = neg_rt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        signed_in = (op == OP_MULT) || (op == OP_DIV);
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_top   = acc_q[2*W-1:W-1];
        div_diff  = div_top - {1'b0, b_q};
        prod      = (neg_rs_q ^ neg_rt_q) ? -acc_q : acc_q;
        quo       = (neg_rs_q ^ neg_rt_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem       = neg_rs_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = S_CALC;
                            cnt_d    = '0;
                            neg_rs_d = signed_in & rs_val[W-1];
                            neg_rt_d = signed_in & rt_val[W-1];
                            acc_d    = {{W{1'b0}}, (neg_rs_d ? -rs_val : rs_val)};
                            b_d      = neg_rt_d ? -rt_val : rt_val;
                            rs_d     = rs_val;
                            is_div_d = op[1];
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                    else              acc_d = {div_top[W-1:0], acc_q[W-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (b_q == '0) begin
                    hi_d = rs_q;
                    lo_d = '1;
                end else begin
                    // most-negative / -1 wraps to most-negative through the normal negate
                    lo_d = quo;
                    hi_d = rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            neg_rs_q <= 1'b0;
            neg_rt_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            rs_q     <= rs_d;
            is_div_q <= is_div_d;
            neg_rs_q <= neg_rs_d;
            neg_rt_q <= neg_rt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table run back-to-back through a
// result scoreboard, plus hand sequences for busy-time requests, reserved ops and reset abort.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] sb_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    int          compared = 0;
    int          failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // called at a negedge; returns just after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs_val = $urandom;
        rt_val = $urandom;
    endtask

    task automatic issue_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el);
        sb_q.push_back({eh, el});
        issue(o, a, b);
    endtask

    task automatic wait_result(input string name, input int exp_busy);
        int          busy_cnt = 0;
        int          cyc = 0;
        int          hold_bad = 0;
        bit          seen = 0;
        logic [63:0] exp;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (done) seen = 1;
            else if (hi !== model_hi || lo !== model_lo) hold_bad++;
        end
        check({name, " done_seen"}, 64'(seen), 64'd1);
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({name, " hold_prior"}, 64'(hold_bad), 64'd0);
        if (sb_q.size() == 0) begin
            check({name, " scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check({name, " hi"}, 64'(hi), 64'(exp[63:32]));
            check({name, " lo"}, 64'(lo), 64'(exp[31:0]));
            model_hi = exp[63:32];
            model_lo = exp[31:0];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;

        vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{3'd3, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        // each vector after the first is issued in the previous one's done cycle
        for (int i = 0; i < 10; i++) begin
            issue_arith(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
            wait_result($sformatf("vec%0d", i), 33);
        end
        @(negedge clk);
        check("done single pulse", 64'(done), 64'd0);
        check("idle busy", 64'(busy), 64'd0);

        // MTHI while busy is dropped; MTLO in the done cycle is taken
        issue_arith(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (5) @(negedge clk);
        issue(3'd4, 32'h0000_AAAA, 32'd0);
        wait_result("busy_mthi", 28);
        issue(3'd5, 32'h0000_5555, 32'd0);
        model_lo = 32'h0000_5555;
        @(negedge clk);
        check("mtlo lo", 64'(lo), 64'h5555);
        check("mtlo hi", 64'(hi), 64'd2);
        check("mtlo busy", 64'(busy), 64'd0);
        check("mtlo done", 64'(done), 64'd0);

        issue(3'd4, 32'h0BAD_F00D, 32'd0);
        model_hi = 32'h0BAD_F00D;
        @(negedge clk);
        check("mthi hi", 64'(hi), 64'h0BAD_F00D);
        check("mthi busy", 64'(busy), 64'd0);

        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        check("op6 busy", 64'(busy), 64'd0);
        check("op6 hi", 64'(hi), 64'(model_hi));
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        @(negedge clk);
        check("op7 busy", 64'(busy), 64'd0);
        check("op7 lo", 64'(lo), 64'(model_lo));
        check("op7 done", 64'(done), 64'd0);

        // asynchronous reset in the middle of a divide
        issue_arith(3'd3, 32'd1000, 32'd3, 32'd1, 32'd333);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort no done", 64'(done_cnt), 64'd0);
        check("abort idle busy", 64'(busy), 64'd0);

        issue_arith(3'd1, 32'd3, 32'd5, 32'd0, 32'd15);
        wait_result("post_reset", 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
